// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and the latched request layout for the memory port arbiter.
package mem_pkg;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b11;

    localparam logic SIGNED   = 1'b1;
    localparam logic UNSIGNED = 1'b0;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    // Bytes touched by an access; the reserved 2'b10 code behaves as a word
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            BYTE:    width_bytes = 3'd1;
            HALF:    width_bytes = 3'd2;
            default: width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response handshakes of the fetch and load/store ports plus the memory-side bus.
interface mem_port_arbiter_if;

    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [1:0]  d_req_width;
    logic        d_req_unsigned;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_in;
    logic        mem_wren;
    logic [1:0]  mem_width;
    logic [31:0] mem_out;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_valid, d_req_addr, d_req_we, d_req_width, d_req_unsigned, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output mem_address, mem_in, mem_wren, mem_width,
        input  mem_out
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_valid, d_req_addr, d_req_we, d_req_width, d_req_unsigned, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  mem_address, mem_in, mem_wren, mem_width,
        output mem_out
    );

endinterface

// File: rtl/mem_load_ext.sv
// Extracts the addressed lane from a big-endian memory word and sign/zero-extends it.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic fill;

    always_comb begin
        fill     = 1'b0;
        result_o = data_i;
        case (width_i)
            BYTE: begin
                fill     = ~unsigned_i & data_i[31];
                result_o = {{24{fill}}, data_i[31:24]};
            end
            HALF: begin
                fill     = ~unsigned_i & data_i[31];
                result_o = {{16{fill}}, data_i[31:16]};
            end
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one synchronous-read byte-lane memory
// and returns registered, one-cycle response strobes.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = 4096,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned STREAK_W = ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [32:0]         MEM_END    = 33'(MEM_BYTES);

    state_e              state_q, state_d;
    req_t                req_q, req_d, new_req;
    logic                new_err;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                grant_d, grant_i, accept;
    logic [31:0]         ext_data;

    logic        i_rsp_valid_q, i_rsp_valid_d;
    logic [31:0] i_rsp_data_q, i_rsp_data_d;
    logic        i_rsp_err_q, i_rsp_err_d;
    logic        d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0] d_rsp_rdata_q, d_rsp_rdata_d;
    logic        d_rsp_err_q, d_rsp_err_d;

    // D wins unless I has been passed over MAX_D_STREAK times in a row
    assign grant_d = bus.d_req_valid && !(bus.i_req_valid && (streak_q == STREAK_MAX));
    assign grant_i = bus.i_req_valid && !grant_d;
    assign accept  = (state_q == IDLE) && (grant_d || grant_i);

    assign bus.d_req_ready = (state_q == IDLE) && grant_d;
    assign bus.i_req_ready = (state_q == IDLE) && grant_i;

    // Candidate request and its range/alignment check
    always_comb begin
        new_req = '0;
        new_err = 1'b0;
        if (grant_d) begin
            new_req.port  = PORT_D;
            new_req.addr  = bus.d_req_addr;
            new_req.we    = bus.d_req_we;
            new_req.width = (bus.d_req_width == BYTE || bus.d_req_width == HALF) ? bus.d_req_width : WORD;
            new_req.uns   = bus.d_req_unsigned;
            new_req.wdata = bus.d_req_wdata;
            new_err       = ({1'b0, bus.d_req_addr} + 33'(width_bytes(bus.d_req_width))) > MEM_END;
        end else begin
            new_req.port  = PORT_I;
            new_req.addr  = bus.i_req_addr;
            new_req.width = WORD;
            new_err       = (bus.i_req_addr[1:0] != 2'b00) ||
                            (({1'b0, bus.i_req_addr} + 33'd4) > MEM_END);
        end
    end

    mem_load_ext u_load_ext (
        .data_i     (bus.mem_out),
        .width_i    (req_q.width),
        .unsigned_i (req_q.uns),
        .result_o   (ext_data)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        streak_d      = streak_q;
        i_rsp_valid_d = 1'b0;
        i_rsp_data_d  = i_rsp_data_q;
        i_rsp_err_d   = i_rsp_err_q;
        d_rsp_valid_d = 1'b0;
        d_rsp_rdata_d = d_rsp_rdata_q;
        d_rsp_err_d   = d_rsp_err_q;

        if (!bus.i_req_valid) begin
            streak_d = '0;
        end else if (accept && grant_i) begin
            streak_d = '0;
        end else if (accept && grant_d && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d = new_req;
                    if (new_err) begin
                        state_d = RESP;
                        if (new_req.port == PORT_D) begin
                            d_rsp_valid_d = 1'b1;
                            d_rsp_err_d   = 1'b1;
                            d_rsp_rdata_d = '0;
                        end else begin
                            i_rsp_valid_d = 1'b1;
                            i_rsp_err_d   = 1'b1;
                            i_rsp_data_d  = '0;
                        end
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_q.we) begin
                    state_d       = RESP;
                    d_rsp_valid_d = 1'b1;
                    d_rsp_err_d   = 1'b0;
                    d_rsp_rdata_d = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = RESP;
                if (req_q.port == PORT_D) begin
                    d_rsp_valid_d = 1'b1;
                    d_rsp_err_d   = 1'b0;
                    d_rsp_rdata_d = ext_data;
                end else begin
                    i_rsp_valid_d = 1'b1;
                    i_rsp_err_d   = 1'b0;
                    i_rsp_data_d  = ext_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= '{port: PORT_I, addr: 32'd0, we: 1'b0, width: WORD, uns: 1'b0, wdata: 32'd0};
            streak_q      <= '0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
            i_rsp_err_q   <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_rdata_q <= '0;
            d_rsp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            streak_q      <= streak_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_rsp_data_q  <= i_rsp_data_d;
            i_rsp_err_q   <= i_rsp_err_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_rsp_rdata_q <= d_rsp_rdata_d;
            d_rsp_err_q   <= d_rsp_err_d;
        end
    end

    // Write enable decodes straight from state so a reset removes it without a clock edge
    assign bus.mem_wren    = (state_q == ISSUE) && req_q.we;
    assign bus.mem_address = req_q.addr;
    assign bus.mem_in      = req_q.wdata;
    assign bus.mem_width   = req_q.width;

    assign bus.i_rsp_valid = i_rsp_valid_q;
    assign bus.i_rsp_data  = i_rsp_data_q;
    assign bus.i_rsp_err   = i_rsp_err_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_rdata = d_rsp_rdata_q;
    assign bus.d_rsp_err   = d_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: big-endian byte memory, transaction-level reference model,
// per-cycle compare process plus literal expectations.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int MEMSZ = 4096;
    localparam int MAXS  = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_BYTES(MEMSZ), .MAX_D_STREAK(MAXS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Memory device: synchronous read, big-endian lanes, writes sized by mem_width
    logic [7:0] mem_dev [MEMSZ];
    bit         mem_init_done = 1'b0;

    function automatic logic [7:0] dev_rd(input int a);
        return (a >= 0 && a < MEMSZ) ? mem_dev[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        int a;
        a = int'(bus.mem_address);
        if (!mem_init_done) begin
            for (int k = 0; k < MEMSZ; k++) mem_dev[k] <= 8'h00;
            mem_init_done <= 1'b1;
        end else if (bus.mem_wren && a >= 0 && a + 4 <= MEMSZ) begin
            case (bus.mem_width)
                BYTE: mem_dev[a] <= bus.mem_in[7:0];
                HALF: begin
                    mem_dev[a]   <= bus.mem_in[15:8];
                    mem_dev[a+1] <= bus.mem_in[7:0];
                end
                default: begin
                    mem_dev[a]   <= bus.mem_in[31:24];
                    mem_dev[a+1] <= bus.mem_in[23:16];
                    mem_dev[a+2] <= bus.mem_in[15:8];
                    mem_dev[a+3] <= bus.mem_in[7:0];
                end
            endcase
        end
        bus.mem_out <= {dev_rd(a), dev_rd(a + 1), dev_rd(a + 2), dev_rd(a + 3)};
    end

    // Reference model: contents seen by requesters, one outstanding transaction
    logic [7:0] ref_mem [MEMSZ];
    bit         ref_init = 1'b0;
    int         cyc, streak, wren_cnt;
    bit         pv, pport, pwe, perr;
    int         pacc, pdue, paddr;
    logic [1:0] pw;
    logic [31:0] pdata, pwd;

    function automatic logic [7:0] ref_rd(input int a);
        return (a >= 0 && a < MEMSZ) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] w, input logic uns);
        logic [31:0] v;
        if (w == BYTE) begin
            v = {24'd0, ref_rd(a)};
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == HALF) begin
            v = {16'd0, ref_rd(a), ref_rd(a + 1)};
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {ref_rd(a), ref_rd(a + 1), ref_rd(a + 2), ref_rd(a + 3)};
        end
        return v;
    endfunction

    always @(negedge clk) begin
        bit idle, gd, gi, ev_i, ev_d, ev_w;
        longint a;
        if (!rst_n) begin
            if (!ref_init) begin
                for (int k = 0; k < MEMSZ; k++) ref_mem[k] = 8'h00;
                ref_init = 1'b1;
            end
            pv = 1'b0; streak = 0; cyc = 0;
        end else begin
            cyc++;
            if (bus.mem_wren) wren_cnt++;
            idle = !pv;
            ev_i = pv && pdue == cyc && pport == PORT_I;
            ev_d = pv && pdue == cyc && pport == PORT_D;
            ev_w = pv && pwe && !perr && cyc == pacc + 1;
            chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(ev_i));
            chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(ev_d));
            chk("mem_wren", 32'(bus.mem_wren), 32'(ev_w));
            if (ev_i) begin
                chk("i_rsp_data", bus.i_rsp_data, pdata);
                chk("i_rsp_err", 32'(bus.i_rsp_err), 32'(perr));
            end
            if (ev_d) begin
                chk("d_rsp_rdata", bus.d_rsp_rdata, pdata);
                chk("d_rsp_err", 32'(bus.d_rsp_err), 32'(perr));
            end
            if (pv && pdue == cyc) begin
                if (pwe && !perr) begin
                    for (int k = 0; k < nbytes(pw); k++)
                        ref_mem[paddr + k] = pwd[8*(nbytes(pw)-1-k) +: 8];
                end
                pv = 1'b0;
            end
            gd = idle && bus.d_req_valid && !(bus.i_req_valid && streak == MAXS);
            gi = idle && bus.i_req_valid && !gd;
            chk("d_req_ready", 32'(bus.d_req_ready), 32'(gd));
            chk("i_req_ready", 32'(bus.i_req_ready), 32'(gi));
            if (gd) begin
                a     = longint'(bus.d_req_addr);
                pport = PORT_D; pwe = bus.d_req_we; pw = bus.d_req_width;
                paddr = int'(bus.d_req_addr); pwd = bus.d_req_wdata;
                perr  = (a + nbytes(pw)) > MEMSZ;
                pdata = (perr || pwe) ? 32'd0 : ref_load(paddr, pw, bus.d_req_unsigned);
                pdue  = cyc + (perr ? 1 : pwe ? 2 : 3);
                pacc  = cyc; pv = 1'b1;
            end else if (gi) begin
                a     = longint'(bus.i_req_addr);
                pport = PORT_I; pwe = 1'b0; pw = WORD; paddr = int'(bus.i_req_addr); pwd = 32'd0;
                perr  = (bus.i_req_addr[1:0] != 2'b00) || (a + 4 > MEMSZ);
                pdata = perr ? 32'd0 : ref_load(paddr, WORD, 1'b0);
                pdue  = cyc + (perr ? 1 : 3);
                pacc  = cyc; pv = 1'b1;
            end
            if (!bus.i_req_valid || gi) streak = 0;
            else if (gd && streak < MAXS) streak++;
        end
    end

    // One request through to its response; lat counts cycles from the accept cycle
    task automatic do_op(input logic port, input logic we, input logic [1:0] w, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
        int n;
        @(posedge clk); #1;
        if (port == PORT_D) begin
            bus.d_req_addr = a; bus.d_req_we = we; bus.d_req_width = w;
            bus.d_req_unsigned = uns; bus.d_req_wdata = wd; bus.d_req_valid = 1'b1;
        end else begin
            bus.i_req_addr = a; bus.i_req_valid = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(port == PORT_D ? bus.d_req_ready : bus.i_req_ready) && n < 50) begin
            @(negedge clk); n++;
        end
        chk("accept seen", 32'(port == PORT_D ? bus.d_req_ready : bus.i_req_ready), 32'd1);
        @(posedge clk); #1;
        bus.d_req_valid = 1'b0; bus.i_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!(port == PORT_D ? bus.d_rsp_valid : bus.i_rsp_valid) && lat < 20);
        rd  = (port == PORT_D) ? bus.d_rsp_rdata : bus.i_rsp_data;
        err = (port == PORT_D) ? bus.d_rsp_err : bus.i_rsp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, acc, nc, gap, rcnt, w0;
        logic        order [$];
        logic        exp_order [12];

        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        wren_cnt = 0;
        bus.i_req_valid = 1'b0; bus.i_req_addr = 32'd0;
        bus.d_req_valid = 1'b0; bus.d_req_addr = 32'd0; bus.d_req_we = 1'b0;
        bus.d_req_width = WORD; bus.d_req_unsigned = 1'b0; bus.d_req_wdata = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst mem_wren", 32'(bus.mem_wren), 32'd0);
        chk("rst mem_address", bus.mem_address, 32'd0);
        chk("rst mem_in", bus.mem_in, 32'd0);
        chk("rst mem_width", 32'(bus.mem_width), 32'd3);
        chk("rst d_rsp", {bus.d_rsp_rdata[29:0], bus.d_rsp_valid, bus.d_rsp_err}, 32'd0);
        chk("rst i_rsp", {bus.i_rsp_data[29:0], bus.i_rsp_valid, bus.i_rsp_err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Word store then load
        do_op(PORT_D, 1'b1, WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("st word lat", 32'(lat), 32'd2);
        chk("st word rdata", rd, 32'd0);
        do_op(PORT_D, 1'b0, WORD, 1'b0, 32'h10, 32'd0, rd, er, lat);
        chk("ld word data", rd, 32'hDEADBEEF);
        chk("ld word lat", 32'(lat), 32'd3);
        chk("ld word err", 32'(er), 32'd0);

        // Byte and half extension
        do_op(PORT_D, 1'b1, BYTE, 1'b0, 32'h21, 32'h0000_0080, rd, er, lat);
        do_op(PORT_D, 1'b0, BYTE, 1'b0, 32'h21, 32'd0, rd, er, lat);
        chk("ld byte signed", rd, 32'hFFFF_FF80);
        do_op(PORT_D, 1'b0, BYTE, 1'b1, 32'h21, 32'd0, rd, er, lat);
        chk("ld byte unsigned", rd, 32'h0000_0080);
        do_op(PORT_D, 1'b1, HALF, 1'b0, 32'h22, 32'h0000_8001, rd, er, lat);
        do_op(PORT_D, 1'b0, HALF, 1'b0, 32'h22, 32'd0, rd, er, lat);
        chk("ld half signed", rd, 32'hFFFF_8001);

        // Both ports requesting continuously
        @(posedge clk); #1;
        bus.i_req_addr = 32'h10; bus.i_req_valid = 1'b1;
        bus.d_req_addr = 32'h10; bus.d_req_we = 1'b0; bus.d_req_width = WORD; bus.d_req_valid = 1'b1;
        acc = 0; nc = 0;
        while (acc < 12 && nc < 300) begin
            @(negedge clk); nc++;
            if (bus.d_req_ready) begin order.push_back(1'b1); acc++; end
            else if (bus.i_req_ready) begin order.push_back(1'b0); acc++; end
        end
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0; bus.d_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("grant count", 32'(order.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            if (k < order.size()) chk($sformatf("grant[%0d] is D", k), 32'(order[k]), 32'(exp_order[k]));

        // Error paths and range boundary
        do_op(PORT_I, 1'b0, WORD, 1'b0, 32'h102, 32'd0, rd, er, lat);
        chk("i misaligned err", 32'(er), 32'd1);
        chk("i misaligned lat", 32'(lat), 32'd1);
        do_op(PORT_I, 1'b0, WORD, 1'b0, 32'h10, 32'd0, rd, er, lat);
        chk("i fetch data", rd, 32'hDEADBEEF);
        w0 = wren_cnt;
        do_op(PORT_D, 1'b1, WORD, 1'b0, 32'hFFF, 32'h12345678, rd, er, lat);
        chk("d oob store err", 32'(er), 32'd1);
        chk("d oob store lat", 32'(lat), 32'd1);
        chk("d oob no write", 32'(wren_cnt - w0), 32'd0);
        do_op(PORT_D, 1'b0, BYTE, 1'b1, 32'hFFF, 32'd0, rd, er, lat);
        chk("d last byte err", 32'(er), 32'd0);

        // Reset while a store sits in ISSUE
        do_op(PORT_D, 1'b1, WORD, 1'b0, 32'h40, 32'h11223344, rd, er, lat);
        @(posedge clk); #1;
        bus.d_req_addr = 32'h40; bus.d_req_we = 1'b1; bus.d_req_width = WORD;
        bus.d_req_wdata = 32'h55667788; bus.d_req_valid = 1'b1;
        nc = 0;
        @(negedge clk);
        while (!bus.d_req_ready && nc < 50) begin @(negedge clk); nc++; end
        @(posedge clk); #1 bus.d_req_valid = 1'b0;
        @(negedge clk);
        chk("wren in ISSUE", 32'(bus.mem_wren), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("wren after async rst", 32'(bus.mem_wren), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("no rsp in reset", {30'd0, bus.d_rsp_valid, bus.i_rsp_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(PORT_D, 1'b0, WORD, 1'b0, 32'h40, 32'd0, rd, er, lat);
        chk("aborted store kept", rd, 32'h11223344);
        chk("post-rst lat", 32'(lat), 32'd3);

        // Back-to-back loads: next accept only after RESP
        @(posedge clk); #1;
        bus.d_req_addr = 32'h10; bus.d_req_we = 1'b0; bus.d_req_width = WORD; bus.d_req_valid = 1'b1;
        nc = 0;
        @(negedge clk);
        while (!bus.d_req_ready && nc < 50) begin @(negedge clk); nc++; end
        @(posedge clk); #1 bus.d_req_addr = 32'h20;
        gap = 0; rcnt = 0;
        do begin
            @(negedge clk); gap++;
            if (bus.d_rsp_valid) rcnt++;
        end while (!bus.d_req_ready && gap < 50);
        chk("b2b accept gap", 32'(gap), 32'd4);
        chk("rsp_valid width", 32'(rcnt), 32'd1);
        @(posedge clk); #1 bus.d_req_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-lane data memory between the instruction-fetch port (I) and the load/store port (D).
- Arbitrates the two requesters and registers the winning request.
- Sequences the memory's one-cycle synchronous read, then returns a registered response.
- Loads are sign- or zero-extended. Out-of-range and misaligned-fetch requests are answered with an error.

Parameters:
MEM_BYTES, 4096, memory size in bytes; byte address must be < MEM_BYTES
MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting; the next grant then goes to I

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  fetch request
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  32  fetch byte address (word read)
i_rsp_valid  out  1  one-cycle fetch response strobe
i_rsp_data  out  32  fetched word
i_rsp_err  out  1  misaligned or out-of-range fetch
d_req_valid  in  1  load/store request
d_req_ready  out  1  load/store request accepted this cycle
d_req_addr  in  32  byte address, any alignment
d_req_we  in  1  1=store, 0=load
d_req_width  in  2  00=byte, 01=half, 11=word, 10 treated as word
d_req_unsigned  in  1  1=zero-extend, 0=sign-extend (loads only)
d_req_wdata  in  32  store data, right-justified
d_rsp_valid  out  1  one-cycle load/store response strobe
d_rsp_rdata  out  32  extended load data; 0 for stores
d_rsp_err  out  1  out-of-range access
mem_address  out  32  to memory address
mem_in  out  32  to memory write data
mem_wren  out  1  to memory write enable
mem_width  out  2  to memory width
mem_out  in  32  from memory; valid one cycle after address is presented; addressed byte in [31:24] (big-endian lane order)

Behaviour:
- Reset and clock:
  - Asynchronous active-low reset; all state is held in flops on rising clk. Reset forces:
    - state IDLE, streak=0, latched request cleared;
    - all rsp_valid/err/data = 0;
    - mem_wren = 0, mem_address/mem_in = 0, mem_width = 11.
  - Reset mid-operation aborts the transfer and emits no response. mem_wren drops immediately (it is decoded from state).
- Handshakes:
  - Accept only in IDLE.
  - grant_d = d_req_valid && !(i_req_valid && streak==MAX_D_STREAK).
  - grant_i = i_req_valid && !grant_d.
  - d_req_ready = IDLE && grant_d; i_req_ready = IDLE && grant_i. Ready may depend on valid.
  - Requesters hold valid and payload stable until ready.
- Streak counter (3 bits min, saturating at MAX_D_STREAK):
  - +1 on a D accept while i_req_valid=1.
  - Cleared on an I accept, and on any cycle where i_req_valid=0.
- On accept: latch port id, addr, we, width, unsigned, wdata.
- Error check at accept:
  - D error: addr + bytes(width) > MEM_BYTES.
  - I error: addr[1:0] != 0, or addr + 4 > MEM_BYTES.
  - On error, go directly to RESP. The memory is never written.
- FSM, registered outputs:
  - IDLE: mem_wren=0. On accept go to ISSUE (or RESP if error).
  - ISSUE (1 cycle): drive mem_address/mem_width/mem_in from the latch. mem_wren = latched we. Stores go to RESP; loads and fetches go to WAIT.
  - WAIT (1 cycle): mem_out valid. Capture the extended result into the response register. Go to RESP.
  - RESP (1 cycle): the selected port's rsp_valid=1 with data/err. Go to IDLE.
- Latency:
  - Read: accept edge to rsp_valid = 3 cycles.
  - Write: 2 cycles.
  - Error: 1 cycle.
  - No new accept until back in IDLE; the earliest next accept is the cycle after RESP.
- Load extraction from mem_out:
  - byte = [31:24], half = [31:16], word = [31:0].
  - Extend per d_req_unsigned. Fetches are word, no extension.
- No response backpressure; requesters must take rsp_valid in the cycle it is asserted.
- The response register holds its value between strobes; only rsp_valid pulses.

Decomposition:
- Package mem_pkg holds:
  - width encodings BYTE=2'b00, HALF=2'b01, WORD=2'b11;
  - SIGNED=1'b1, UNSIGNED=1'b0;
  - FSM state enum {IDLE, ISSUE, WAIT, RESP};
  - port id constants PORT_I/PORT_D.
- One combinational sub-module, mem_load_ext (mem_out, width, unsigned -> 32-bit result), reused by the future cache fill path.

Test Plan:
- D store word 0xDEADBEEF @0x10, then D load word @0x10 -> mem_wren pulses 1 cycle in ISSUE; d_rsp_rdata=0xDEADBEEF 3 cycles after load accept, err=0.
- Store byte 0x80 @0x21; load byte signed and unsigned @0x21 -> 0xFFFFFF80 then 0x00000080; half-load signed @0x22 of stored 0x8001 -> 0xFFFF8001.
- I and D valid together every cycle for 12 requests, MAX_D_STREAK=4 -> grant order D,D,D,D,I repeating; no starvation.
- I fetch @0x102 -> i_rsp_err=1, 1 cycle after accept, no memory access; D store @0xFFF width word -> d_rsp_err=1, mem_wren never asserted.
- Assert rst_n=0 during ISSUE of a store -> mem_wren falls without a clock edge, no rsp_valid, memory location unchanged, next accept works normally.
- Back-to-back D loads -> second d_req_ready only in the cycle after the first RESP; rsp_valid exactly one cycle wide.
